// File: rtl/foo_pkg.sv
// Shared definitions for the foo operand feeder and its downstream consumers.
//   DATA_W / LONG_W : operand widths of foo.a and foo.long_in
//   PKT_BEATS       : beats in one well-formed operand packet
//   state_t         : feeder FSM states
//   foo_operands_t  : the operand pair as presented to foo
package foo_pkg;

    localparam int DATA_W    = 64;
    localparam int LONG_W    = 129;
    localparam int PKT_BEATS = 4;

    typedef enum logic [2:0] {
        S_A,      // waiting for beat0 (a operand)
        S_L0,     // waiting for beat1 (long_in[63:0])
        S_L1,     // waiting for beat2 (long_in[127:64])
        S_L2,     // waiting for beat3 (long_in[128], must carry last)
        S_PEND,   // packet complete, commit blocked by hold
        S_DRAIN   // malformed packet, discarding beats up to last
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [LONG_W-1:0] long_in;
    } foo_operands_t;

endpackage

// File: rtl/foo_sat_cnt.sv
// Saturating up-counter.
//   clk, rst : clock and synchronous active-high reset
//   inc      : count one event this cycle
//   cnt      : current count, sticks at all-ones
module foo_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state is updated with <= only, so every always_ff
    // reads the pre-edge value of every register regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/foo_in_pack.sv
// Assembles a 4-beat valid/ready stream into foo's a / long_in operands and
// updates both in a single edge so foo never evaluates a half-new pair.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : beat handshake (in_ready low only while a commit is stalled)
//   in_data, in_last  : beat payload and end-of-packet marker
//   hold              : downstream stall, blocks the commit while high
//   a, long_in        : committed operands
//   upd               : one-cycle pulse when new operands first appear
//   err               : one-cycle pulse on a malformed packet
//   pkt_cnt, err_cnt  : wrapping commit count, saturating error count
module foo_in_pack #(
    parameter int DATA_W = foo_pkg::DATA_W,
    parameter int LONG_W = foo_pkg::LONG_W,
    parameter int ERR_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              hold,
    output logic [DATA_W-1:0] a,
    output logic [LONG_W-1:0] long_in,
    output logic              upd,
    output logic              err,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [ERR_W-1:0]  err_cnt
);

    import foo_pkg::*;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   stage_a;
    logic [LONG_W-1:0]   stage_l;
    logic [LONG_W-1:0]   commit_long;
    logic                xfer;
    logic                commit;
    logic                proto_err;

    assign in_ready = (state != S_PEND);
    assign xfer     = in_valid && in_ready;

    // A commit straight out of S_L2 takes the top bit from the beat on the
    // bus; out of S_PEND it was already captured into staging.
    assign commit_long = (state == S_L2) ? {in_data[0], stage_l[LONG_W-2:0]} : stage_l;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        proto_err = 1'b0;
        case (state)
            S_A: if (xfer) begin
                if (in_last) proto_err = 1'b1;
                else         state_nxt = S_L0;
            end
            S_L0: if (xfer) begin
                if (in_last) begin proto_err = 1'b1; state_nxt = S_A; end
                else         state_nxt = S_L1;
            end
            S_L1: if (xfer) begin
                if (in_last) begin proto_err = 1'b1; state_nxt = S_A; end
                else         state_nxt = S_L2;
            end
            S_L2: if (xfer) begin
                if (!in_last) begin
                    proto_err = 1'b1;
                    state_nxt = S_DRAIN;
                end else if (hold) begin
                    state_nxt = S_PEND;
                end else begin
                    commit    = 1'b1;
                    state_nxt = S_A;
                end
            end
            S_PEND: if (!hold) begin
                commit    = 1'b1;
                state_nxt = S_A;
            end
            S_DRAIN: if (xfer && in_last) state_nxt = S_A;
            default: state_nxt = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_A;
            a       <= '0;
            long_in <= '0;
            upd     <= 1'b0;
            err     <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            state <= state_nxt;
            upd   <= commit;
            err   <= proto_err;
            if (commit) begin
                a       <= stage_a;
                long_in <= commit_long;
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: staging is pure datapath with no reset; every byte is overwritten
    // by a transfer before any commit can read it, so reset only needs to
    // return the FSM to S_A to discard a partial packet.
    always_ff @(posedge clk) begin
        if (!rst && xfer) begin
            case (state)
                S_A:     stage_a                     <= in_data;
                S_L0:    stage_l[DATA_W-1:0]         <= in_data;
                S_L1:    stage_l[2*DATA_W-1:DATA_W]  <= in_data;
                S_L2:    stage_l[LONG_W-1]           <= in_data[0];
                default: ;
            endcase
        end
    end

    foo_sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (proto_err),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_foo_in_pack.sv
module tb_foo_in_pack;

    import foo_pkg::*;

    localparam int SE_W = 2;   // narrow counters on a second instance to reach saturation / wrap
    localparam int SC_W = 2;

    localparam logic [DATA_W-1:0] B0 = 64'h1111_2222_3333_4444;
    localparam logic [DATA_W-1:0] B1 = 64'hAAAA_0000_0000_0001;
    localparam logic [DATA_W-1:0] B2 = 64'h8000_0000_0000_0000;
    localparam logic [DATA_W-1:0] B3 = 64'h0000_0000_0000_0001;
    localparam logic [LONG_W-1:0] LNOM = {1'b1, B2, B1};

    logic clk = 1'b0;
    logic rst, in_valid, in_last, hold;
    logic [DATA_W-1:0] in_data;

    logic              in_ready, upd, err;
    logic [DATA_W-1:0] a;
    logic [LONG_W-1:0] long_in;
    logic [31:0]       pkt_cnt;
    logic [15:0]       err_cnt;

    logic              s_in_ready, s_upd, s_err;
    logic [DATA_W-1:0] s_a;
    logic [LONG_W-1:0] s_long;
    logic [SC_W-1:0]   s_pkt;
    logic [SE_W-1:0]   s_ec;

    always #5 clk = ~clk;

    foo_in_pack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .hold(hold),
        .a(a), .long_in(long_in), .upd(upd), .err(err),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    foo_in_pack #(.ERR_W(SE_W), .CNT_W(SC_W)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .hold(hold),
        .a(s_a), .long_in(s_long), .upd(s_upd), .err(s_err),
        .pkt_cnt(s_pkt), .err_cnt(s_ec)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [LONG_W-1:0] act, input logic [LONG_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a list of beats collected for the current packet plus
    // two flags, evaluated from the packet rules once per clock edge.
    logic [DATA_W-1:0] mq[$];
    bit                m_drain, m_pend, m_upd, m_err;
    foo_operands_t     m_ops;
    logic [31:0]       m_pkt;
    int                m_errs;
    bit                last_ready;

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_commit();
        m_ops.a       = mq[0];
        m_ops.long_in = {mq[3][0], mq[2], mq[1]};
        m_upd = 1'b1;
        m_pkt++;
        mq.delete();
        m_pend = 1'b0;
    endtask

    task automatic model_edge(input bit r, input bit v, input bit l, input bit h, input logic [DATA_W-1:0] d);
        m_upd = 1'b0;
        m_err = 1'b0;
        if (r) begin
            mq.delete();
            m_drain = 0; m_pend = 0;
            m_ops = '0; m_pkt = '0; m_errs = 0;
        end else if (m_pend) begin
            if (!h) model_commit();
        end else if (v) begin
            if (m_drain) begin
                if (l) m_drain = 0;
            end else begin
                mq.push_back(d);
                if (l) begin
                    if (mq.size() < PKT_BEATS) begin
                        m_err = 1; m_errs++; mq.delete();
                    end else if (h) begin
                        m_pend = 1;
                    end else begin
                        model_commit();
                    end
                end else if (mq.size() == PKT_BEATS) begin
                    m_err = 1; m_errs++; mq.delete(); m_drain = 1;
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, check ready before the rising
    // edge, check registered outputs at the next falling edge.
    task automatic step(input bit r, input bit v, input bit l, input bit h, input logic [DATA_W-1:0] d);
        rst = r; in_valid = v; in_last = l; hold = h; in_data = d;
        #1;
        last_ready = in_ready;
        if (!r) begin
            check("in_ready", in_ready, !m_pend);
            check("s_in_ready", s_in_ready, !m_pend);
        end
        model_edge(r, v, l, h, d);
        @(posedge clk);
        @(negedge clk);
        check("a", a, m_ops.a);
        check("long_in", long_in, m_ops.long_in);
        check("upd", upd, m_upd);
        check("err", err, m_err);
        check("pkt_cnt", pkt_cnt, m_pkt);
        check("err_cnt", err_cnt, sat(m_errs, 16));
        check("s_a", s_a, m_ops.a);
        check("s_long", s_long, m_ops.long_in);
        check("s_upd", s_upd, m_upd);
        check("s_err", s_err, m_err);
        check("s_pkt", s_pkt, m_pkt[SC_W-1:0]);
        check("s_err_cnt", s_ec, sat(m_errs, SE_W));
    endtask

    task automatic send_pkt(input logic [DATA_W-1:0] d0, d1, d2, d3);
        step(0, 1, 0, 0, d0);
        step(0, 1, 0, 0, d1);
        step(0, 1, 0, 0, d2);
        step(0, 1, 1, 0, d3);
    endtask

    typedef struct {
        bit                v, l, h;
        logic [DATA_W-1:0] d;
        bit                e_rdy, e_upd, e_err;
        logic [DATA_W-1:0] e_a;
        logic [LONG_W-1:0] e_long;
        logic [31:0]       e_pkt;
        logic [15:0]       e_ec;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // nominal packet, then an early last on beat1
        tbl[0] = '{1'b1, 1'b0, 1'b0, B0,          1'b1, 1'b0, 1'b0, 64'h0, 129'h0, 32'd0, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, B1,          1'b1, 1'b0, 1'b0, 64'h0, 129'h0, 32'd0, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, B2,          1'b1, 1'b0, 1'b0, 64'h0, 129'h0, 32'd0, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, B3,          1'b1, 1'b1, 1'b0, B0,    LNOM,   32'd1, 16'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 64'h0,       1'b1, 1'b0, 1'b0, B0,    LNOM,   32'd1, 16'd0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 64'h55,      1'b1, 1'b0, 1'b0, B0,    LNOM,   32'd1, 16'd0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 64'h66,      1'b1, 1'b0, 1'b1, B0,    LNOM,   32'd1, 16'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 64'h0,       1'b1, 1'b0, 1'b0, B0,    LNOM,   32'd1, 16'd1};

        rst = 1; in_valid = 0; in_last = 0; hold = 0; in_data = '0;
        @(negedge clk);
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        check("reset_a", a, '0);
        check("reset_long", long_in, '0);
        check("reset_pkt", pkt_cnt, '0);

        for (int i = 0; i < 8; i++) begin
            step(0, tbl[i].v, tbl[i].l, tbl[i].h, tbl[i].d);
            check("tbl_ready", last_ready, tbl[i].e_rdy);
            check("tbl_upd", upd, tbl[i].e_upd);
            check("tbl_err", err, tbl[i].e_err);
            check("tbl_a", a, tbl[i].e_a);
            check("tbl_long", long_in, tbl[i].e_long);
            check("tbl_pkt", pkt_cnt, tbl[i].e_pkt);
            check("tbl_err_cnt", err_cnt, tbl[i].e_ec);
        end

        // hold stall: beat3 with hold high, stalled 5 cycles, then release
        step(0, 1, 0, 0, 64'h0123_4567_89AB_CDEF);
        step(0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 1, 0, 0, 64'h0);
        step(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, 64'hDEAD);
            check("hold_ready", last_ready, 1'b0);
            check("hold_a", a, B0);
            check("hold_long", long_in, LNOM);
        end
        step(0, 0, 0, 0, '0);
        check("hold_upd", upd, 1'b1);
        check("hold_a_new", a, 64'h0123_4567_89AB_CDEF);
        check("hold_long_new", long_in, {1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
        check("hold_pkt", pkt_cnt, 32'd2);

        // missing last, two junk beats, then a good packet
        step(0, 1, 0, 0, 64'h10);
        step(0, 1, 0, 0, 64'h11);
        step(0, 1, 0, 0, 64'h12);
        step(0, 1, 0, 0, 64'h13);
        check("miss_err", err, 1'b1);
        check("miss_err_cnt", err_cnt, 16'd2);
        step(0, 1, 0, 0, 64'h14);
        step(0, 1, 1, 0, 64'h15);
        check("drain_no_err", err, 1'b0);
        check("drain_pkt", pkt_cnt, 32'd2);
        send_pkt(64'h20, 64'h21, 64'h22, 64'h23);
        check("after_drain_a", a, 64'h20);
        check("after_drain_pkt", pkt_cnt, 32'd3);

        // reset in the middle of a packet
        step(0, 1, 0, 0, 64'h30);
        step(0, 1, 0, 0, 64'h31);
        step(0, 1, 0, 0, 64'h32);
        step(1, 1, 0, 0, 64'h33);
        check("mid_rst_a", a, '0);
        check("mid_rst_long", long_in, '0);
        check("mid_rst_pkt", pkt_cnt, '0);
        check("mid_rst_err_cnt", err_cnt, '0);
        send_pkt(64'h40, 64'h41, 64'h42, 64'h43);
        check("post_rst_a", a, 64'h40);
        check("post_rst_long", long_in, {1'b1, 64'h42, 64'h41});
        check("post_rst_pkt", pkt_cnt, 32'd1);

        // randomized traffic against the model; mostly well-formed packets
        begin
            int k;
            bit r, v, l, h;
            k = 0;
            for (int i = 0; i < 3000; i++) begin
                r = ($urandom_range(0, 299) == 0);
                v = ($urandom_range(0, 3) != 0);
                h = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 9) < 2) l = $urandom_range(0, 1) == 1;
                else                          l = ((k % 4) == 3);
                if (v) k++;
                step(r, v, l, h, {$urandom, $urandom});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
